// File: rtl/console_pkg.sv
// Shared constants and types for the console transmit queue: MMIO offsets,
// queued entry layout and STATUS register bit positions.
package console_pkg;

    localparam logic [7:0] CONSOLE_STATUS_ADDR   = 8'h00;
    localparam logic [7:0] CONSOLE_CHAR_OUT_ADDR = 8'h04;
    localparam logic [7:0] CONSOLE_SIM_CTRL_ADDR = 8'h08;

    localparam int unsigned STATUS_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_LEVEL_LSB = 8;

    typedef struct packed {
        logic [7:0]  off;
        logic [31:0] data;
    } console_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, free-running wrap-around pointers
// and an explicit fill-level counter; push at full and pop at empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        full_o  = (level_q == (AW+1)'(DEPTH));
        empty_o = (level_q == '0);
        level_o = level_q;
        rdata_o = mem_q[rptr_q];
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/console_tx_queue.sv
// MMIO front end for the simulation console: queues CHAR_OUT/SIM_CTRL writes,
// back-pressures the bus at full and drains entries in order at a fixed pace.
module console_tx_queue
    import console_pkg::*;
#(
    parameter int unsigned Depth         = 16,
    parameter int unsigned DrainInterval = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        con_req_o,
    output logic        con_we_o,
    output logic [31:0] con_addr_o,
    output logic [31:0] con_wdata_o
);
    localparam int unsigned LW = $clog2(Depth) + 1;
    localparam int unsigned CW = (DrainInterval > 1) ? $clog2(DrainInterval) : 1;

    logic [7:0]     off;
    logic           unused_addr;
    logic           fifo_full, fifo_empty;
    logic [LW-1:0]  fifo_level;
    console_entry_t wr_entry, head;
    logic           mapped_wr, push, pop, rd_req;
    logic [31:0]    status;

    logic [CW-1:0]  drain_q, drain_d;
    logic           con_req_q;
    logic [31:0]    con_addr_q, con_addr_d, con_wdata_q, con_wdata_d;
    logic           rvalid_q;
    logic [31:0]    rdata_q, rdata_d;

    assign off         = addr_i[7:0];
    assign unused_addr = ^addr_i[31:8];

    always_comb begin
        mapped_wr = (off == CONSOLE_CHAR_OUT_ADDR) || (off == CONSOLE_SIM_CTRL_ADDR);
        // Full is taken before this cycle's pop, so a draining slot is only reusable next cycle
        gnt_o     = req_i & (~we_i | ~fifo_full);
        push      = req_i & we_i & ~fifo_full & mapped_wr;
        pop       = ~fifo_empty & (drain_q == '0);
        rd_req    = req_i & ~we_i;
        wr_entry.off  = off;
        wr_entry.data = wdata_i;

        status                              = '0;
        status[STATUS_EMPTY_BIT]            = fifo_empty;
        status[STATUS_FULL_BIT]             = fifo_full;
        status[STATUS_LEVEL_LSB +: 8]       = 8'(fifo_level);

        drain_d = drain_q;
        if (pop)                 drain_d = CW'(DrainInterval - 1);
        else if (drain_q != '0)  drain_d = drain_q - 1'b1;

        con_addr_d  = con_addr_q;
        con_wdata_d = con_wdata_q;
        if (pop) begin
            con_addr_d  = {24'h0, head.off};
            con_wdata_d = head.data;
        end

        rdata_d = '0;
        if (rd_req && (off == CONSOLE_STATUS_ADDR)) rdata_d = status;
    end

    sync_fifo #(
        .WIDTH ($bits(console_entry_t)),
        .DEPTH (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            drain_q     <= '0;
            con_req_q   <= 1'b0;
            con_addr_q  <= '0;
            con_wdata_q <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            drain_q     <= drain_d;
            con_req_q   <= pop;
            con_addr_q  <= con_addr_d;
            con_wdata_q <= con_wdata_d;
            rvalid_q    <= rd_req;
            rdata_q     <= rdata_d;
        end
    end

    assign con_req_o   = con_req_q;
    assign con_we_o    = con_req_q;
    assign con_addr_o  = con_addr_q;
    assign con_wdata_o = con_wdata_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;

endmodule
